// File: rtl/snake_engine.sv
// snake_engine: grid-cell snake game core. Keeps the body as a shift register
// of cells, steps it on each tick, handles growth, walls or wrap and
// self-collision, and answers registered per-cell occupancy queries.
module snake_engine #(
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    parameter int GRID_W   = 64,
    parameter int GRID_H   = 48,
    parameter int WRAP     = 0,
    localparam int X_W     = $clog2(GRID_W),
    localparam int Y_W     = $clog2(GRID_H),
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             VGA_clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             tick,
    input  logic             dir_up,
    input  logic             dir_left,
    input  logic             dir_down,
    input  logic             dir_right,
    input  logic [X_W-1:0]   apple_x,
    input  logic [Y_W-1:0]   apple_y,
    input  logic [X_W-1:0]   q_x,
    input  logic [Y_W-1:0]   q_y,
    output logic             q_head,
    output logic             q_body,
    output logic [X_W-1:0]   head_x,
    output logic [Y_W-1:0]   head_y,
    output logic [LEN_W-1:0] length,
    output logic             ate,
    output logic             game_over,
    output logic             running
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} state_t;
    // Opposite directions differ only in bit 1, so a reversal is heading ^ 2'b10.
    typedef enum logic [1:0] {D_UP = 2'd0, D_RIGHT = 2'd1, D_DOWN = 2'd2, D_LEFT = 2'd3} dir_t;

    state_t           state_q, state_d;
    dir_t             heading_q, heading_d;
    dir_t             pending_q, pending_d;
    logic [X_W-1:0]   seg_x_q [MAX_LEN];
    logic [X_W-1:0]   seg_x_d [MAX_LEN];
    logic [Y_W-1:0]   seg_y_q [MAX_LEN];
    logic [Y_W-1:0]   seg_y_d [MAX_LEN];
    logic [LEN_W-1:0] length_q, length_d;
    logic             ate_q, ate_d;
    logic             q_head_q, q_head_d;
    logic             q_body_q, q_body_d;

    logic             req_valid;
    dir_t             req_dir;
    dir_t             step_dir;
    logic [X_W-1:0]   nh_x;
    logic [Y_W-1:0]   nh_y;
    logic             wall_hit;
    logic             self_hit;
    logic             grow;
    logic [LEN_W-1:0] check_lim;

    assign head_x    = seg_x_q[0];
    assign head_y    = seg_y_q[0];
    assign length    = length_q;
    assign ate       = ate_q;
    assign q_head    = q_head_q;
    assign q_body    = q_body_q;
    assign game_over = (state_q == S_OVER);
    assign running   = (state_q == S_RUN);

    // Decode a one-hot direction request; anything else leaves pending alone.
    always_comb begin
        req_valid = $onehot({dir_up, dir_left, dir_down, dir_right});
        req_dir   = D_RIGHT;
        if (dir_up)        req_dir = D_UP;
        else if (dir_left) req_dir = D_LEFT;
        else if (dir_down) req_dir = D_DOWN;
    end

    // Next head cell, wall test (compare before increment) and collision test.
    always_comb begin
        step_dir = (pending_q == dir_t'(heading_q ^ 2'b10)) ? heading_q : pending_q;
        nh_x     = seg_x_q[0];
        nh_y     = seg_y_q[0];
        wall_hit = 1'b0;
        case (step_dir)
            D_UP: begin
                if (seg_y_q[0] == '0) begin
                    wall_hit = (WRAP == 0);
                    nh_y     = Y_W'(GRID_H - 1);
                end else nh_y = seg_y_q[0] - 1'b1;
            end
            D_DOWN: begin
                if (seg_y_q[0] == Y_W'(GRID_H - 1)) begin
                    wall_hit = (WRAP == 0);
                    nh_y     = '0;
                end else nh_y = seg_y_q[0] + 1'b1;
            end
            D_LEFT: begin
                if (seg_x_q[0] == '0) begin
                    wall_hit = (WRAP == 0);
                    nh_x     = X_W'(GRID_W - 1);
                end else nh_x = seg_x_q[0] - 1'b1;
            end
            default: begin
                if (seg_x_q[0] == X_W'(GRID_W - 1)) begin
                    wall_hit = (WRAP == 0);
                    nh_x     = '0;
                end else nh_x = seg_x_q[0] + 1'b1;
            end
        endcase
        grow = (nh_x == apple_x) && (nh_y == apple_y) && !wall_hit;
        // Without growth the tail cell is vacated this step, so it is excluded.
        check_lim = grow ? length_q : length_q - 1'b1;
        self_hit  = 1'b0;
        for (int k = 1; k < MAX_LEN; k++) begin
            if (LEN_W'(k) < check_lim && seg_x_q[k] == nh_x && seg_y_q[k] == nh_y)
                self_hit = 1'b1;
        end
    end

    // Occupancy query against the current body, registered one cycle later.
    always_comb begin
        q_head_d = (length_q != '0) && (seg_x_q[0] == q_x) && (seg_y_q[0] == q_y);
        q_body_d = 1'b0;
        for (int k = 1; k < MAX_LEN; k++) begin
            if (LEN_W'(k) < length_q && seg_x_q[k] == q_x && seg_y_q[k] == q_y)
                q_body_d = 1'b1;
        end
        // The head query wins so the two flags never assert together.
        if (q_head_d) q_body_d = 1'b0;
    end

    // Game state machine: start/stop, stepping, growth and death.
    always_comb begin
        state_d   = state_q;
        heading_d = heading_q;
        pending_d = pending_q;
        length_d  = length_q;
        ate_d     = 1'b0;
        seg_x_d   = seg_x_q;
        seg_y_d   = seg_y_q;
        if (state_q == S_RUN && req_valid) pending_d = req_dir;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    heading_d = D_RIGHT;
                    pending_d = D_RIGHT;
                    length_d  = LEN_W'(INIT_LEN);
                    for (int k = 0; k < MAX_LEN; k++) begin
                        if (k < INIT_LEN) begin
                            seg_x_d[k] = X_W'(GRID_W / 2 - k);
                            seg_y_d[k] = Y_W'(GRID_H / 2);
                        end
                    end
                end
            end
            S_RUN: begin
                if (!start) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    heading_d = step_dir;
                    if (wall_hit || self_hit) begin
                        state_d = S_OVER;
                    end else begin
                        for (int k = 1; k < MAX_LEN; k++) begin
                            seg_x_d[k] = seg_x_q[k-1];
                            seg_y_d[k] = seg_y_q[k-1];
                        end
                        seg_x_d[0] = nh_x;
                        seg_y_d[0] = nh_y;
                        if (grow) begin
                            ate_d = 1'b1;
                            if (length_q != LEN_W'(MAX_LEN)) length_d = length_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                if (!start) state_d = S_IDLE;
            end
        endcase
    end

    // State and body registers with asynchronous clear.
    always_ff @(posedge VGA_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            heading_q <= D_RIGHT;
            pending_q <= D_RIGHT;
            length_q  <= '0;
            ate_q     <= 1'b0;
            q_head_q  <= 1'b0;
            q_body_q  <= 1'b0;
            for (int k = 0; k < MAX_LEN; k++) begin
                seg_x_q[k] <= '0;
                seg_y_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            heading_q <= heading_d;
            pending_q <= pending_d;
            length_q  <= length_d;
            ate_q     <= ate_d;
            q_head_q  <= q_head_d;
            q_body_q  <= q_body_d;
            seg_x_q   <= seg_x_d;
            seg_y_q   <= seg_y_d;
        end
    end

endmodule

// File: tb/tb_snake_engine.sv
// tb_snake_engine: directed bench for snake_engine. Three instances share the
// stimulus: default (wall), WRAP=1, and MAX_LEN=4.
module tb_snake_engine;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       start = 1'b0;
    logic       tick = 1'b0;
    logic       dir_up = 1'b0, dir_left = 1'b0, dir_down = 1'b0, dir_right = 1'b0;
    logic [5:0] apple_x = 6'd5, apple_y = 6'd5;
    logic [5:0] q_x = 6'd0, q_y = 6'd0;

    logic       qh_a, qb_a, ate_a, go_a, run_a;
    logic [5:0] hx_a, hy_a;
    logic [4:0] len_a;
    logic       qh_w, qb_w, ate_w, go_w, run_w;
    logic [5:0] hx_w, hy_w;
    logic [4:0] len_w;
    logic       qh_m, qb_m, ate_m, go_m, run_m;
    logic [5:0] hx_m, hy_m;
    logic [2:0] len_m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    snake_engine dut_a (
        .VGA_clk(clk), .reset_n(reset_n), .start(start), .tick(tick),
        .dir_up(dir_up), .dir_left(dir_left), .dir_down(dir_down), .dir_right(dir_right),
        .apple_x(apple_x), .apple_y(apple_y), .q_x(q_x), .q_y(q_y),
        .q_head(qh_a), .q_body(qb_a), .head_x(hx_a), .head_y(hy_a), .length(len_a),
        .ate(ate_a), .game_over(go_a), .running(run_a)
    );

    snake_engine #(.WRAP(1)) dut_w (
        .VGA_clk(clk), .reset_n(reset_n), .start(start), .tick(tick),
        .dir_up(dir_up), .dir_left(dir_left), .dir_down(dir_down), .dir_right(dir_right),
        .apple_x(apple_x), .apple_y(apple_y), .q_x(q_x), .q_y(q_y),
        .q_head(qh_w), .q_body(qb_w), .head_x(hx_w), .head_y(hy_w), .length(len_w),
        .ate(ate_w), .game_over(go_w), .running(run_w)
    );

    snake_engine #(.MAX_LEN(4)) dut_m (
        .VGA_clk(clk), .reset_n(reset_n), .start(start), .tick(tick),
        .dir_up(dir_up), .dir_left(dir_left), .dir_down(dir_down), .dir_right(dir_right),
        .apple_x(apple_x), .apple_y(apple_y), .q_x(q_x), .q_y(q_y),
        .q_head(qh_m), .q_body(qb_m), .head_x(hx_m), .head_y(hy_m), .length(len_m),
        .ate(ate_m), .game_over(go_m), .running(run_m)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    // d: 0 up, 1 left, 2 down, 3 right. One request cycle, then a tick.
    task automatic move(input int d);
        case (d)
            0: dir_up = 1'b1;
            1: dir_left = 1'b1;
            2: dir_down = 1'b1;
            default: dir_right = 1'b1;
        endcase
        cyc();
        {dir_up, dir_left, dir_down, dir_right} = 4'b0000;
        do_tick();
    endtask

    task automatic restart();
        start = 1'b0;
        cyc();
        start = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        repeat (2) cyc();
        checks++; if (run_a !== 1'b0) begin errors++; $display("FAIL reset_running: got %0d want 0", run_a); end
        checks++; if (go_a !== 1'b0) begin errors++; $display("FAIL reset_game_over: got %0d want 0", go_a); end
        checks++; if (len_a !== 5'd0) begin errors++; $display("FAIL reset_length: got %0d want 0", len_a); end
        checks++; if (hx_a !== 6'd0 || hy_a !== 6'd0) begin errors++; $display("FAIL reset_head: got (%0d,%0d) want (0,0)", hx_a, hy_a); end
        checks++; if (ate_a !== 1'b0) begin errors++; $display("FAIL reset_ate: got %0d want 0", ate_a); end
        checks++; if (qh_a !== 1'b0 || qb_a !== 1'b0) begin errors++; $display("FAIL reset_query: got h=%0d b=%0d want 0 0", qh_a, qb_a); end
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_start_query();
        start = 1'b1;
        cyc();
        checks++; if (run_a !== 1'b1) begin errors++; $display("FAIL start_running: got %0d want 1", run_a); end
        checks++; if (hx_a !== 6'd32 || hy_a !== 6'd24) begin errors++; $display("FAIL start_head: got (%0d,%0d) want (32,24)", hx_a, hy_a); end
        checks++; if (len_a !== 5'd3) begin errors++; $display("FAIL start_length: got %0d want 3", len_a); end
        q_x = 6'd31; q_y = 6'd24;
        cyc();
        checks++; if (qb_a !== 1'b1 || qh_a !== 1'b0) begin errors++; $display("FAIL query_body: got h=%0d b=%0d want 0 1", qh_a, qb_a); end
        q_x = 6'd32;
        cyc();
        checks++; if (qh_a !== 1'b1 || qb_a !== 1'b0) begin errors++; $display("FAIL query_head: got h=%0d b=%0d want 1 0", qh_a, qb_a); end
        q_x = 6'd29;
        cyc();
        checks++; if (qh_a !== 1'b0 || qb_a !== 1'b0) begin errors++; $display("FAIL query_empty: got h=%0d b=%0d want 0 0", qh_a, qb_a); end
    endtask

    task automatic test_straight_reversal();
        repeat (3) do_tick();
        checks++; if (hx_a !== 6'd35 || hy_a !== 6'd24) begin errors++; $display("FAIL straight_head: got (%0d,%0d) want (35,24)", hx_a, hy_a); end
        move(1);
        checks++; if (hx_a !== 6'd36 || hy_a !== 6'd24) begin errors++; $display("FAIL reversal_head: got (%0d,%0d) want (36,24)", hx_a, hy_a); end
        move(0);
        checks++; if (hx_a !== 6'd36 || hy_a !== 6'd23) begin errors++; $display("FAIL turn_up_head: got (%0d,%0d) want (36,23)", hx_a, hy_a); end
        checks++; if (len_a !== 5'd3 || run_a !== 1'b1) begin errors++; $display("FAIL turn_up_state: got len=%0d run=%0d want 3 1", len_a, run_a); end
    endtask

    task automatic test_wall_wrap();
        restart();
        tick = 1'b1;
        repeat (31) cyc();
        tick = 1'b0;
        checks++; if (hx_a !== 6'd63 || hx_w !== 6'd63) begin errors++; $display("FAIL edge_reach: got a=%0d w=%0d want 63 63", hx_a, hx_w); end
        do_tick();
        checks++; if (go_a !== 1'b1 || run_a !== 1'b0) begin errors++; $display("FAIL wall_over: got go=%0d run=%0d want 1 0", go_a, run_a); end
        checks++; if (hx_a !== 6'd63 || hy_a !== 6'd24) begin errors++; $display("FAIL wall_frozen: got (%0d,%0d) want (63,24)", hx_a, hy_a); end
        checks++; if (hx_w !== 6'd0 || hy_w !== 6'd24) begin errors++; $display("FAIL wrap_head: got (%0d,%0d) want (0,24)", hx_w, hy_w); end
        checks++; if (go_w !== 1'b0 || run_w !== 1'b1) begin errors++; $display("FAIL wrap_state: got go=%0d run=%0d want 0 1", go_w, run_w); end
        start = 1'b0;
        cyc();
        checks++; if (go_a !== 1'b0 || run_a !== 1'b0) begin errors++; $display("FAIL over_to_idle: got go=%0d run=%0d want 0 0", go_a, run_a); end
    endtask

    task automatic test_growth();
        restart();
        apple_x = 6'd33; apple_y = 6'd24;
        do_tick();
        checks++; if (ate_a !== 1'b1 || len_a !== 5'd4) begin errors++; $display("FAIL grow_first: got ate=%0d len=%0d want 1 4", ate_a, len_a); end
        checks++; if (ate_m !== 1'b1 || len_m !== 3'd4) begin errors++; $display("FAIL grow_first_m: got ate=%0d len=%0d want 1 4", ate_m, len_m); end
        cyc();
        checks++; if (ate_a !== 1'b0) begin errors++; $display("FAIL ate_one_cycle: got %0d want 0", ate_a); end
        apple_x = 6'd34;
        do_tick();
        checks++; if (ate_a !== 1'b1 || len_a !== 5'd5) begin errors++; $display("FAIL grow_second: got ate=%0d len=%0d want 1 5", ate_a, len_a); end
        checks++; if (ate_m !== 1'b1 || len_m !== 3'd4) begin errors++; $display("FAIL grow_saturate: got ate=%0d len=%0d want 1 4", ate_m, len_m); end
        apple_x = 6'd5; apple_y = 6'd5;
    endtask

    task automatic test_self_collision();
        move(0);
        move(1);
        move(2);
        checks++; if (go_a !== 1'b1) begin errors++; $display("FAIL self_hit_len5: got go=%0d want 1", go_a); end
        checks++; if (hx_a !== 6'd33 || hy_a !== 6'd23) begin errors++; $display("FAIL self_hit_frozen: got (%0d,%0d) want (33,23)", hx_a, hy_a); end
        checks++; if (go_m !== 1'b0 || hx_m !== 6'd33 || hy_m !== 6'd24) begin errors++; $display("FAIL tail_follow_m: got go=%0d head=(%0d,%0d) want 0 (33,24)", go_m, hx_m, hy_m); end
    endtask

    task automatic test_tail_follow();
        restart();
        apple_x = 6'd33; apple_y = 6'd24;
        do_tick();
        apple_x = 6'd5; apple_y = 6'd5;
        move(0);
        move(1);
        move(2);
        checks++; if (go_a !== 1'b0 || run_a !== 1'b1) begin errors++; $display("FAIL tail_follow_state: got go=%0d run=%0d want 0 1", go_a, run_a); end
        checks++; if (hx_a !== 6'd32 || hy_a !== 6'd24 || len_a !== 5'd4) begin errors++; $display("FAIL tail_follow_head: got (%0d,%0d) len=%0d want (32,24) 4", hx_a, hy_a, len_a); end
    endtask

    task automatic test_tail_apple();
        restart();
        apple_x = 6'd33; apple_y = 6'd24;
        do_tick();
        apple_x = 6'd5; apple_y = 6'd5;
        move(0);
        move(1);
        apple_x = 6'd32; apple_y = 6'd24;
        move(2);
        checks++; if (go_a !== 1'b1 || run_a !== 1'b0) begin errors++; $display("FAIL tail_apple_over: got go=%0d run=%0d want 1 0", go_a, run_a); end
        checks++; if (hx_a !== 6'd32 || hy_a !== 6'd23) begin errors++; $display("FAIL tail_apple_frozen: got (%0d,%0d) want (32,23)", hx_a, hy_a); end
        apple_x = 6'd5; apple_y = 6'd5;
    endtask

    task automatic test_priority();
        restart();
        repeat (2) do_tick();
        start = 1'b0;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        checks++; if (run_a !== 1'b0 || go_a !== 1'b0) begin errors++; $display("FAIL stop_priority_state: got run=%0d go=%0d want 0 0", run_a, go_a); end
        checks++; if (hx_a !== 6'd34 || hy_a !== 6'd24) begin errors++; $display("FAIL stop_priority_head: got (%0d,%0d) want (34,24)", hx_a, hy_a); end
    endtask

    task automatic test_async_reset();
        restart();
        q_x = 6'd32; q_y = 6'd24;
        cyc();
        checks++; if (qh_a !== 1'b1 || run_a !== 1'b1) begin errors++; $display("FAIL pre_reset: got qh=%0d run=%0d want 1 1", qh_a, run_a); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (run_a !== 1'b0 || go_a !== 1'b0 || ate_a !== 1'b0) begin errors++; $display("FAIL async_state: got run=%0d go=%0d ate=%0d want 0 0 0", run_a, go_a, ate_a); end
        checks++; if (len_a !== 5'd0 || hx_a !== 6'd0 || hy_a !== 6'd0) begin errors++; $display("FAIL async_body: got len=%0d head=(%0d,%0d) want 0 (0,0)", len_a, hx_a, hy_a); end
        checks++; if (qh_a !== 1'b0 || qb_a !== 1'b0) begin errors++; $display("FAIL async_query: got h=%0d b=%0d want 0 0", qh_a, qb_a); end
        start = 1'b0;
        reset_n = 1'b1;
        cyc();
    endtask

    initial begin
        test_reset();
        test_start_query();
        test_straight_reversal();
        test_wall_wrap();
        test_growth();
        test_self_collision();
        test_tail_follow();
        test_tail_apple();
        test_priority();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/snake_engine.md
Name: snake_engine

Overview:
- Parametrised grid-cell game core for the VGA snake display. Holds the snake body as a shift register of up to MAX_LEN cells and advances it one cell per tick pulse.
- Handles direction latching with reversal rejection, wall or wrap boundary mode, apple growth and self-collision.
- Answers per-pixel occupancy queries from the renderer with fixed 1-cycle latency.
- Sits between the update-tick divider and the VGA colour logic.

Parameters:
- MAX_LEN, 16, maximum segments (≥ INIT_LEN, ≥ 2)
- INIT_LEN, 3, length on game start (≥ 1)
- GRID_W, 64, grid columns; X_W = clog2(GRID_W)
- GRID_H, 48, grid rows; Y_W = clog2(GRID_H)
- WRAP, 0, 1 = wrap at edges; 0 = leaving the grid ends the game

Ports:
- VGA_clk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  level; 1 = play, 0 = return to idle
- tick  in  1  one-cycle step pulse, synchronous to VGA_clk
- dir_up, dir_left, dir_down, dir_right  in  1 each  direction request
- apple_x  in  X_W  apple column
- apple_y  in  Y_W  apple row
- q_x  in  X_W  query column
- q_y  in  Y_W  query row
- q_head  out  1  query cell is the head (registered)
- q_body  out  1  query cell is a non-head segment (registered)
- head_x  out  X_W  current head column
- head_y  out  Y_W  current head row
- length  out  clog2(MAX_LEN+1)  current segment count
- ate  out  1  one-cycle pulse, apple consumed
- game_over  out  1  level, high in OVER state
- running  out  1  level, high in RUN state

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0. length 0. Segment registers 0. Heading RIGHT. Pending direction RIGHT.
- States:
  - IDLE→RUN when start=1. On entry: head = (GRID_W/2, GRID_H/2); segment k = (GRID_W/2−k, GRID_H/2) for k < INIT_LEN; length = INIT_LEN; heading and pending = RIGHT.
  - RUN→IDLE when start=0, which has priority over a same-cycle tick.
  - RUN→OVER on a fatal step.
  - OVER→IDLE when start=0. Segments are frozen in OVER.
- Direction input:
  - Exactly one dir_* high loads pending direction on any cycle in RUN.
  - All low or multi-hot: pending direction unchanged.
  - Pending opposite to the current heading is discarded at the step; heading is kept.
- Step, on a tick in RUN (tick outside RUN is ignored). With tick at edge N, results are visible after edge N+1:
  - heading ← pending direction, unless it is a reversal.
  - nh = head + heading, ±1 cell.
  - Edge with WRAP=1: column wraps 0↔GRID_W−1, row wraps 0↔GRID_H−1.
  - Edge with WRAP=0: leaving the grid is fatal. Segments are unchanged.
  - grow = (nh == apple) && no wall death.
  - Self-collision checks nh against segments 1..length−2 when not growing (the tail cell vacates), or 1..length−1 when growing. A hit is fatal and segments are unchanged.
  - Not fatal: segment[k] ← segment[k−1] for k ≥ 1; segment[0] ← nh.
  - grow: ate=1 for that one cycle, and length ← min(length+1, MAX_LEN). At MAX_LEN, ate still pulses and length holds.
  - Segments at index ≥ length are don't-care and never affect collision or query.
- Query: 1-cycle latency in all states.
  - q_head(N+1) = (length>0 && (q_x,q_y)==segment[0]) at N.
  - q_body(N+1) = any k in 1..length−1 matches.
  - The two are mutually exclusive.
- Width rule: all coordinate arithmetic is modulo within X_W/Y_W. Wall detection uses a compare before the increment (col==GRID_W−1 moving right, col==0 moving left, and the same for rows), not overflow.

Test Plan:
- Reset and start: reset_n=0 then 1, start=1 → running=1 next cycle, head (32,24), length 3. Query (31,24) → q_body=1 one cycle later. Query (32,24) → q_head=1.
- Straight run and reversal: 3 ticks → head (35,24). Then dir_left pulse + tick → head (36,24), heading still RIGHT. Then dir_up + tick → head (36,23).
- Boundaries:
  - WRAP=0: drive right until head (63,24), tick → game_over=1, head stays (63,24), running=0. Then start=0 → IDLE, game_over=0.
  - WRAP=1, same stimulus → head (0,24), no game_over.
- Growth and saturation: apple at (33,24), tick → ate=1 for exactly one cycle, length 4.
  - MAX_LEN=4: a second apple → ate=1, length stays 4.
- Self-collision vs tail-follow, length 5:
  - Steps up, left, down close a square onto segment 3 → game_over.
  - Length 4 with the same loop enters the vacating tail cell → no game_over.
  - Same as length 4, but with the apple placed on the tail cell → game_over.
- Priority and mid-run exit: start=0 and tick on the same cycle in RUN → IDLE, head unchanged. Async reset_n=0 mid-RUN → all outputs 0 immediately.
